// File: rtl/svram_sdram_bridge_pkg.sv
// rtl/svram_sdram_bridge_pkg.sv - shared types and constants for the slow VRAM to SDRAM bridge
package svram_sdram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    localparam logic [1:0] CYC_FIX = 2'b00;
    localparam logic [1:0] CYC_CPU = 2'b01;
    localparam logic [1:0] CYC_SPR = 2'b10;

    localparam int LAT_W = 3;

    // Put the addressed word in [15:0] and its pair partner in [31:16].
    function automatic logic [31:0] pair_align(input logic [31:0] pair, input logic odd);
        return odd ? {pair[15:0], pair[31:16]} : pair;
    endfunction

endpackage

// File: rtl/svram_pair_cache.sv
// rtl/svram_pair_cache.sv - one-entry word-pair cache with hit compare and in-place half update
module svram_pair_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill,
    input  logic [13:0] fill_pair,
    input  logic [31:0] fill_data,
    input  logic        upd,
    input  logic [13:0] upd_pair,
    input  logic        upd_sel,
    input  logic [15:0] upd_data,
    input  logic [13:0] look_pair,
    output logic        hit,
    output logic [31:0] look_data
);

    logic        vld;
    logic [13:0] pair;
    logic [31:0] data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            pair <= '0;
            data <= '0;
        end else if (fill) begin
            vld  <= 1'b1;
            pair <= fill_pair;
            data <= fill_data;
        end else if (upd && vld && (upd_pair == pair)) begin
            if (upd_sel) data[31:16] <= upd_data;
            else         data[15:0]  <= upd_data;
        end
    end

    assign hit       = vld && (look_pair == pair);
    assign look_data = data;

endmodule

// File: rtl/svram_sdram_bridge.sv
// rtl/svram_sdram_bridge.sv - slow VRAM SRAM-style bus to SDRAM req/ack bridge; SVRAM_PAIRCACHE_EN adds a pair cache
module svram_sdram_bridge
    import svram_sdram_bridge_pkg::*;
#(
    parameter logic [23:0] SDR_BASE = 24'h000000,
    parameter int          MAX_LAT  = 3
) (
    input  logic        CLK_24M,
    input  logic        RESETP,
    input  logic [14:0] SVRAM_ADDR,
    input  logic [15:0] SVRAM_DATA_OUT,
    input  logic        BOE,
    input  logic        BWE,
    input  logic [1:0]  VRAM_CYCLE,
    output logic [31:0] SVRAM_DATA_IN,
    output logic        SDR_REQ,
    output logic        SDR_WE,
    output logic [23:0] SDR_ADDR,
    output logic [15:0] SDR_WDATA,
    output logic        SDR_WSEL,
    output logic        SDR_PRIO,
    input  logic        SDR_ACK,
    input  logic [31:0] SDR_RDATA,
    output logic        BUSY,
    output logic        LATE_ERR
);

    localparam logic [LAT_W-1:0] LAT_SAT   = '1;
    localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(MAX_LAT);

    state_t state, state_nx;

    logic [14:0] addr_s;
    logic        boe_s, bwe_s, bwe_s_d;
    logic [1:0]  cyc_s;

    logic        last_vld;
    logic [14:0] last_addr;

    logic        wr_pend, rd_pend;
    logic [14:0] wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_cyc, rd_cyc;

    logic [14:0] cur_addr;
    logic [15:0] cur_wdata;
    logic        cur_prio;

    logic [LAT_W-1:0] lat_cnt;
    logic [31:0]      data_in_q;
    logic             late_q;

    logic        wr_trig, rd_trig, wr_go, rd_go;
    logic [14:0] wr_addr_e, rd_addr_e;
    logic [15:0] wr_data_e;
    logic [1:0]  wr_cyc_e, rd_cyc_e;
    logic        take_wr, take_rd;
    logic        cache_hit;
    logic [31:0] cache_pair;

    // The in-flight read keeps re-triggering until last_addr updates, so it is masked here.
    assign wr_trig = bwe_s_d & ~bwe_s;
    assign rd_trig = ~boe_s & bwe_s & (~last_vld | (addr_s != last_addr))
                   & ~((state == ST_RD) & (addr_s == cur_addr));

    // A trigger this cycle counts as pending so IDLE can launch without an extra cycle.
    assign wr_go     = wr_pend | wr_trig;
    assign rd_go     = rd_pend | rd_trig;
    assign wr_addr_e = wr_trig ? addr_s         : wr_addr;
    assign wr_data_e = wr_trig ? SVRAM_DATA_OUT : wr_data;
    assign wr_cyc_e  = wr_trig ? cyc_s          : wr_cyc;
    assign rd_addr_e = rd_trig ? addr_s         : rd_addr;
    assign rd_cyc_e  = rd_trig ? cyc_s          : rd_cyc;

`ifdef SVRAM_PAIRCACHE_EN
    svram_pair_cache u_pair_cache (
        .clk       (CLK_24M),
        .rst       (RESETP),
        .fill      ((state == ST_RD) && SDR_ACK),
        .fill_pair (cur_addr[14:1]),
        .fill_data (SDR_RDATA),
        .upd       (take_wr),
        .upd_pair  (wr_addr_e[14:1]),
        .upd_sel   (wr_addr_e[0]),
        .upd_data  (wr_data_e),
        .look_pair (rd_addr_e[14:1]),
        .hit       (cache_hit),
        .look_data (cache_pair)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_pair = '0;
`endif

    always_ff @(posedge CLK_24M or posedge RESETP) begin
        if (RESETP) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        take_wr  = 1'b0;
        take_rd  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_go) begin
                    take_wr  = 1'b1;
                    state_nx = ST_WR;
                end else if (rd_go) begin
                    take_rd = 1'b1;
                    if (!cache_hit) state_nx = ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                if (SDR_ACK) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_24M or posedge RESETP) begin
        if (RESETP) begin
            addr_s    <= '0;
            boe_s     <= 1'b1;
            bwe_s     <= 1'b1;
            bwe_s_d   <= 1'b1;
            cyc_s     <= CYC_FIX;
            last_vld  <= 1'b0;
            last_addr <= '0;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            wr_data   <= '0;
            wr_cyc    <= CYC_FIX;
            rd_cyc    <= CYC_FIX;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cur_prio  <= 1'b0;
            lat_cnt   <= '0;
            data_in_q <= '0;
            late_q    <= 1'b0;
        end else begin
            addr_s  <= SVRAM_ADDR;
            boe_s   <= BOE;
            bwe_s   <= BWE;
            bwe_s_d <= bwe_s;
            cyc_s   <= VRAM_CYCLE;

            wr_pend <= wr_go & ~take_wr;
            rd_pend <= rd_go & ~take_rd;
            if (wr_trig) begin
                wr_addr <= addr_s;
                wr_data <= SVRAM_DATA_OUT;
                wr_cyc  <= cyc_s;
            end
            if (rd_trig) begin
                rd_addr <= addr_s;
                rd_cyc  <= cyc_s;
            end

            if (take_wr) begin
                cur_addr  <= wr_addr_e;
                cur_wdata <= wr_data_e;
                cur_prio  <= (wr_cyc_e == CYC_SPR);
                lat_cnt   <= '0;
            end else if (take_rd && cache_hit) begin
                data_in_q <= pair_align(cache_pair, rd_addr_e[0]);
                last_addr <= rd_addr_e;
                last_vld  <= 1'b1;
            end else if (take_rd) begin
                cur_addr <= rd_addr_e;
                cur_prio <= (rd_cyc_e == CYC_SPR);
                lat_cnt  <= '0;
            end else if ((state != ST_IDLE) && !SDR_ACK && (lat_cnt != LAT_SAT)) begin
                lat_cnt <= lat_cnt + 1'b1;
            end

            if ((state != ST_IDLE) && ((SDR_ACK && (lat_cnt > LAT_LIMIT)) || (lat_cnt == LAT_SAT)))
                late_q <= 1'b1;

            if ((state == ST_RD) && SDR_ACK) begin
                data_in_q <= pair_align(SDR_RDATA, cur_addr[0]);
                last_addr <= cur_addr;
                last_vld  <= 1'b1;
            end
            if ((state == ST_WR) && SDR_ACK)
                last_vld <= 1'b0;
        end
    end

    assign SDR_REQ       = (state != ST_IDLE);
    assign SDR_WE        = (state == ST_WR);
    assign BUSY          = SDR_REQ;
    assign SDR_ADDR      = SDR_BASE + {10'd0, cur_addr[14:1]};
    assign SDR_WDATA     = cur_wdata;
    assign SDR_WSEL      = cur_addr[0];
    assign SDR_PRIO      = cur_prio;
    assign SVRAM_DATA_IN = data_in_q;
    assign LATE_ERR      = late_q;

endmodule

// File: doc/svram_sdram_bridge.md
Name: svram_sdram_bridge

Overview:
- Sits directly downstream of the slow VRAM cycle generator.
- Turns its SRAM-style bus (SVRAM_ADDR, BOE, BWE, SVRAM_DATA_OUT, VRAM_CYCLE hint) into req/ack transactions on one SDRAM controller port.
- Returns the 32-bit word pair that feeds the generator's SVRAM_DATA_IN, so sprite-map even and odd words are latched together.
- Tracks the latency budget of every access and flags late completions.

Parameters:
- SDR_BASE, 24'h000000, SDRAM word-pair base address of the slow VRAM region.
- MAX_LAT, 3, CLK_24M cycles allowed from request to ack before LATE_ERR is set (slow VRAM is a 3-mclk part).

Ports:
- CLK_24M  in  1  master clock; all state on the rising edge.
- RESETP  in  1  asynchronous, active-high reset.
- SVRAM_ADDR  in  15  word address from the slow cycle generator.
- SVRAM_DATA_OUT  in  16  write data from the slow cycle generator.
- BOE  in  1  active-low output enable.
- BWE  in  1  active-low write enable.
- VRAM_CYCLE  in  2  cycle hint: 10 = sprite map, 01 = CPU, 00 = fix map.
- SVRAM_DATA_IN  out  32  read pair; [15:0] = mem[A], [31:16] = the other word of the aligned pair.
- SDR_REQ  out  1  request, held until ack.
- SDR_WE  out  1  1 = write.
- SDR_ADDR  out  24  SDR_BASE + SVRAM_ADDR[14:1].
- SDR_WDATA  out  16  write data.
- SDR_WSEL  out  1  which half of the pair is written (= A[0]).
- SDR_PRIO  out  1  1 when the latched hint is sprite map.
- SDR_ACK  in  1  one-cycle completion pulse.
- SDR_RDATA  in  32  aligned pair {mem[2n+1], mem[2n]}; valid with SDR_ACK.
- BUSY  out  1  transaction outstanding.
- LATE_ERR  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values: SVRAM_DATA_IN=0, SDR_REQ=0, SDR_WE=0, SDR_ADDR=SDR_BASE, SDR_WDATA=0, SDR_WSEL=0, SDR_PRIO=0, BUSY=0, LATE_ERR=0.
- Reset internals: last_addr invalid, lat_cnt=0.
- Reset mid-transaction: the request is dropped and SDR_REQ falls asynchronously. The controller must tolerate an abandoned request.
- Input sampling: SVRAM_ADDR, BOE, BWE, VRAM_CYCLE are registered once; the one-cycle-old values are called the samples.
- Write trigger: falling edge of sampled BWE. Capture addr, data and hint at that edge.
- Read trigger: sampled BOE=0 and sampled BWE=1, with the address differing from last_addr or last_addr invalid.
- States:
  - IDLE: a pending write wins; else a pending read; else stay.
  - RD_REQ: SDR_REQ=1, SDR_WE=0. On SDR_ACK, register SVRAM_DATA_IN: if A[0]=0, {RDATA[31:16], RDATA[15:0]}; if A[0]=1, {RDATA[15:0], RDATA[31:16]}. Set last_addr=A and go to IDLE.
  - WR_REQ: SDR_REQ=1, SDR_WE=1. On SDR_ACK, invalidate last_addr and go to IDLE.
- Read data is visible one cycle after SDR_ACK. Best-case read latency is 3 cycles from the address change: sample, request, ack, then the output register.
- Pending flags: one write and one read, each a single entry. A trigger re-arriving while its flag is set overwrites the captured fields (latest wins).
- Simultaneous write and read triggers: both flags are set; the write is served first.
- SDR_PRIO, SDR_ADDR, SDR_WDATA and SDR_WSEL stay stable while SDR_REQ=1.
- BUSY=1 in RD_REQ and WR_REQ.
- Latency: lat_cnt is cleared on entry to a REQ state and increments each cycle until ack, saturating at 7. LATE_ERR is set if ack arrives with lat_cnt > MAX_LAT, or if lat_cnt reaches 7.
- An SDR_ACK in IDLE is ignored.

Optional Feature:
- SVRAM_PAIRCACHE_EN defined:
  - A one-entry pair cache holds the last returned RDATA with its pair address.
  - A read whose A[14:1] hits a valid entry completes from the IDLE decision without SDR_REQ, so data appears 1 cycle earlier.
  - A write to the same pair updates the cached half in place.
  - Reset invalidates the cache.
- Undefined: every read goes to SDRAM, and writes only invalidate last_addr.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_RD, ST_WR;
  - VRAM_CYCLE codes CYC_FIX=2'b00, CYC_CPU=2'b01, CYC_SPR=2'b10;
  - lat_cnt width (3).
- One natural sub-module: svram_pair_cache, the cache entry with hit compare and half update. It is instantiated only under the macro.

Test Plan:
- Read even: mem pair 0x0100 = {0xBEEF, 0x1234}; ADDR=0x0200, BOE=0; ack after 2 cycles -> SDR_ADDR=SDR_BASE+0x100 and SVRAM_DATA_IN=0xBEEF_1234 one cycle after ack.
- Read odd: same pair, ADDR=0x0201 -> SVRAM_DATA_IN=0x1234_BEEF; LATE_ERR stays 0.
- Write: BWE falls with ADDR=0x7A03, DATA=0x5A5A -> SDR_WE=1, SDR_WSEL=1, SDR_WDATA=0x5A5A; the following read of 0x7A03 reissues SDR_REQ.
- Simultaneous: BWE falls while a read trigger is pending -> write served first, then the read; exactly two acks consumed.
- Latency: ack withheld 5 cycles with MAX_LAT=3 -> LATE_ERR=1 and it stays 1 until RESETP.
- Reset mid-RD_REQ: RESETP pulsed -> SDR_REQ=0 immediately, SVRAM_DATA_IN=0, next read is issued normally.
